dmem_wait_ctrl: RTL and testbench

DMEM_WAIT_CTRL -- requirements
Module: dmem_wait_ctrl

---
 rtl/dmem_wait_ctrl.sv | 107 ++++++++++
 tb/tb_dmem_wait_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_wait_ctrl.sv
// dmem_wait_ctrl: wait-state controller between a core data port and a single-cycle ssram
// Ports: clk/rst (sync active-high); cpu_* request side (address, read/write enables held until
// cpu_read_rdy/cpu_write_ack, byte lanes, write data, read data); mem_* ssram side (word address,
// strobes, lanes, write data, read data valid the cycle after mem_read_enable); bus_error sticky flag.
module dmem_wait_ctrl #(
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] cpu_address,
   input  logic        cpu_read_enable,
   input  logic        cpu_write_enable,
   input  logic [3:0]  cpu_byte_enable,
   input  logic [31:0] cpu_write_data,
   output logic [31:0] cpu_read_data,
   output logic        cpu_read_rdy,
   output logic        cpu_write_ack,
   output logic [31:0] mem_address,
   output logic        mem_read_enable,
   output logic        mem_write_enable,
   output logic [3:0]  mem_byte_enable,
   output logic [31:0] mem_write_data,
   input  logic [31:0] mem_read_data,
   output logic        bus_error
);
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;
   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        wr_q, wr_d;
   logic        bad_q, bad_d;
   logic        err_q, err_d;
   logic        req;
   logic        lanes_ok;
   assign req      = cpu_write_enable | cpu_read_enable;
   assign lanes_ok = cpu_byte_enable inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      wr_d    = wr_q;
      bad_d   = bad_q;
      err_d   = err_q;
      unique case (state_q)
         S_IDLE: if (req) begin
            // a write wins when both enables are high; the collision itself is the error
            addr_d  = {2'b00, cpu_address[31:2]};
            be_d    = cpu_byte_enable;
            wdata_d = cpu_write_data;
            wr_d    = cpu_write_enable;
            bad_d   = cpu_write_enable & ~lanes_ok;
            err_d   = err_q | (cpu_write_enable & (cpu_read_enable | ~lanes_ok));
            cnt_d   = 4'(WAIT_STATES);
            state_d = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
         end
         S_WAIT: begin
            cnt_d   = cnt_q - 4'd1;
            state_d = (cnt_q == 4'd1) ? S_ACCESS : S_WAIT;
         end
         S_ACCESS: state_d = wr_q ? S_IDLE : S_RESP;
         S_RESP: begin
            rdata_d = mem_read_data;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         wr_q    <= 1'b0;
         bad_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         wr_q    <= wr_d;
         bad_q   <= bad_d;
         err_q   <= err_d;
      end
   end
   assign mem_address      = addr_q;
   assign mem_byte_enable  = be_q;
   assign mem_write_data   = wdata_q;
   assign mem_write_enable = (state_q == S_ACCESS) & wr_q & ~bad_q;
   assign mem_read_enable  = (state_q == S_ACCESS) & ~wr_q;
   assign cpu_write_ack    = (state_q == S_ACCESS) & wr_q;
   assign cpu_read_rdy     = (state_q == S_RESP);
   // read data passes straight through in RESP and is held from the register afterwards
   assign cpu_read_data    = (state_q == S_RESP) ? mem_read_data : rdata_q;
   assign bus_error        = err_q;
endmodule

// File: tb/tb_dmem_wait_ctrl.sv
// tb_dmem_wait_ctrl: vector table plus corner sequences on three instances (WAIT_STATES 1, 0, 3)
module tb_dmem_wait_ctrl;
   logic        clk = 1'b0;
   logic        rst [3];
   logic [31:0] addr [3];
   logic        re [3];
   logic        we [3];
   logic [3:0]  be [3];
   logic [31:0] wd [3];
   logic [31:0] rdata [3];
   logic        rdy [3];
   logic        ack [3];
   logic [31:0] maddr [3];
   logic        mre [3];
   logic        mwe [3];
   logic [3:0]  mbe [3];
   logic [31:0] mwd [3];
   logic        berr [3];
   int          errors = 0;
   int          checks = 0;
   always #5 clk = ~clk;
   for (genvar g = 0; g < 3; g++) begin : gen_dut
      logic [31:0] mem [256];
      logic [31:0] mrd;
      dmem_wait_ctrl #(.WAIT_STATES(g == 0 ? 1 : g == 1 ? 0 : 3)) u_dut (
         .clk(clk), .rst(rst[g]),
         .cpu_address(addr[g]), .cpu_read_enable(re[g]), .cpu_write_enable(we[g]),
         .cpu_byte_enable(be[g]), .cpu_write_data(wd[g]),
         .cpu_read_data(rdata[g]), .cpu_read_rdy(rdy[g]), .cpu_write_ack(ack[g]),
         .mem_address(maddr[g]), .mem_read_enable(mre[g]), .mem_write_enable(mwe[g]),
         .mem_byte_enable(mbe[g]), .mem_write_data(mwd[g]), .mem_read_data(mrd),
         .bus_error(berr[g])
      );
      // single-cycle ssram: registered read, lane-masked write
      always @(posedge clk) begin
         if (mwe[g])
            for (int i = 0; i < 4; i++)
               if (mbe[g][i]) mem[maddr[g][7:0]][8*i +: 8] <= mwd[g][8*i +: 8];
         if (mre[g]) mrd <= mem[maddr[g][7:0]];
      end
   end
   typedef struct {
      bit is_rd;
      int lat;
   } exp_t;
   exp_t q[$];
   typedef struct {
      bit          wr;
      bit          rd;
      logic [31:0] a;
      logic [3:0]  be;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      bit          exp_strobe;
      bit          exp_err;
   } vec_t;
   vec_t vt [12];
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask
   task automatic pulse_rst(input int d);
      @(negedge clk);
      rst[d] = 1'b1;
      we[d] = 1'b0;
      re[d] = 1'b0;
      @(negedge clk);
      rst[d] = 1'b0;
   endtask
   task automatic chk_idle(input int d, input string nm);
      chk({nm, " ack"}, 32'(ack[d]), 0);
      chk({nm, " rdy"}, 32'(rdy[d]), 0);
      chk({nm, " strobes"}, 32'({mwe[d], mre[d]}), 0);
      chk({nm, " mem_address"}, maddr[d], 0);
      chk({nm, " read_data"}, rdata[d], 0);
      chk({nm, " bus_error"}, 32'(berr[d]), 0);
   endtask
   // Drives one request (held for nresp completions), pushes expected responses, then
   // pops them as ack/rdy appear; latency counts negedges after the sampling edge.
   task automatic xact(input int d, input int ws, input bit wr, input bit rd, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] w, input int nresp,
                       input logic [31:0] exp_rd, input bit exp_strobe, input bit exp_err);
      int strobes = 0;
      int got = 0;
      exp_t e;
      for (int k = 0; k < nresp; k++)
         q.push_back('{is_rd: !wr, lat: (wr ? ws + 1 : ws + 2) + k * (ws + 2)});
      @(negedge clk);
      we[d] = wr;
      re[d] = rd;
      addr[d] = a;
      be[d] = b;
      wd[d] = w;
      for (int n = 1; n <= (ws + 3) * nresp + 2; n++) begin
         @(negedge clk);
         if (mwe[d] || mre[d]) begin
            strobes++;
            chk("mem_address", maddr[d], a >> 2);
         end
         if (ack[d] || rdy[d]) begin
            if (q.size() == 0) chk("spurious response", 32'({ack[d], rdy[d]}), 0);
            else begin
               e = q.pop_front();
               chk("response kind rdy", 32'(rdy[d]), 32'(e.is_rd));
               chk("latency", n, e.lat);
               if (rdy[d]) chk("read_data", rdata[d], exp_rd);
               got++;
               if (got == nresp) begin
                  we[d] = 1'b0;
                  re[d] = 1'b0;
               end
            end
         end
      end
      we[d] = 1'b0;
      re[d] = 1'b0;
      chk("missing responses", q.size(), 0);
      q.delete();
      chk("strobe count", strobes, exp_strobe ? nresp : 0);
      chk("bus_error", 32'(berr[d]), 32'(exp_err));
      if (!wr) chk("read_data hold", rdata[d], exp_rd);
   endtask
   initial begin
      vt[0]  = '{1, 0, 32'h100, 4'hF, 32'hDEADBEEF, 32'h0, 1, 0};
      vt[1]  = '{0, 1, 32'h100, 4'hF, 32'h0, 32'hDEADBEEF, 1, 0};
      vt[2]  = '{1, 0, 32'h104, 4'h3, 32'h00001234, 32'h0, 1, 0};
      vt[3]  = '{1, 0, 32'h104, 4'hC, 32'hABCD0000, 32'h0, 1, 0};
      vt[4]  = '{0, 1, 32'h104, 4'h0, 32'h0, 32'hABCD1234, 1, 0};
      vt[5]  = '{1, 0, 32'h108, 4'h1, 32'h00000055, 32'h0, 1, 0};
      vt[6]  = '{1, 0, 32'h108, 4'h2, 32'h00006600, 32'h0, 1, 0};
      vt[7]  = '{1, 0, 32'h108, 4'h4, 32'h00770000, 32'h0, 1, 0};
      vt[8]  = '{1, 0, 32'h108, 4'h8, 32'h88000000, 32'h0, 1, 0};
      vt[9]  = '{0, 1, 32'h10B, 4'h5, 32'h0, 32'h88776655, 1, 0};
      vt[10] = '{1, 0, 32'h100, 4'h5, 32'hFFFFFFFF, 32'h0, 0, 1};
      vt[11] = '{0, 1, 32'h100, 4'hF, 32'h0, 32'hDEADBEEF, 1, 1};
      for (int d = 0; d < 3; d++) begin
         rst[d] = 1'b1;
         re[d] = 1'b0;
         we[d] = 1'b0;
         addr[d] = '0;
         be[d] = '0;
         wd[d] = '0;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 3; d++) rst[d] = 1'b0;
      for (int d = 0; d < 3; d++) chk_idle(d, "reset");
      for (int i = 0; i < 12; i++)
         xact(0, 1, vt[i].wr, vt[i].rd, vt[i].a, vt[i].be, vt[i].wd, 1,
              vt[i].exp_rd, vt[i].exp_strobe, vt[i].exp_err);
      pulse_rst(0);
      chk("bus_error cleared by rst", 32'(berr[0]), 0);
      xact(0, 1, 1, 1, 32'h10C, 4'hF, 32'h12345678, 1, 32'h0, 1, 1);
      xact(0, 1, 0, 1, 32'h10C, 4'hF, 32'h0, 1, 32'h12345678, 1, 1);
      xact(1, 0, 1, 0, 32'h200, 4'hF, 32'hCAFEF00D, 2, 32'h0, 1, 0);
      xact(1, 0, 0, 1, 32'h200, 4'h0, 32'h0, 1, 32'hCAFEF00D, 1, 0);
      xact(1, 0, 1, 0, 32'h204, 4'h6, 32'h11111111, 1, 32'h0, 0, 1);
      @(negedge clk);
      we[2] = 1'b1;
      addr[2] = 32'h300;
      be[2] = 4'hF;
      wd[2] = 32'h0BADF00D;
      repeat (2) @(negedge clk);
      rst[2] = 1'b1;
      we[2] = 1'b0;
      @(negedge clk);
      rst[2] = 1'b0;
      for (int n = 0; n < 6; n++) begin
         chk_idle(2, "abort");
         @(negedge clk);
      end
      xact(2, 3, 1, 0, 32'h300, 4'hF, 32'h0BADF00D, 1, 32'h0, 1, 0);
      xact(2, 3, 0, 1, 32'h300, 4'hF, 32'h0, 1, 32'h0BADF00D, 1, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
